// File: rtl/pu_isa_pkg.sv
// Shared 16-bit PU ISA definitions: request kinds, opcode prefixes, condition
// codes, ALU ops and field widths used by the encoder and the PU decoder.
package pu_isa_pkg;

  localparam int INS_W  = 16;
  localparam int REG_W  = 2;
  localparam int OP_W   = 4;
  localparam int COND_W = 3;
  localparam int IMM_W  = 16;
  localparam int KIND_W = 3;
  localparam int STEP_W = 2;

  typedef enum logic [KIND_W-1:0] {
    K_LDC  = 3'd0,
    K_CAL  = 3'd1,
    K_LDM  = 3'd2,
    K_STM  = 3'd3,
    K_FARJ = 3'd4,
    K_BRR  = 3'd5,
    K_HALT = 3'd6,
    K_NOP  = 3'd7
  } req_kind_e;

  localparam logic [5:0]       OPC_LI     = 6'b000001;
  localparam logic [3:0]       OPC_LIL    = 4'b0100;
  localparam logic [3:0]       OPC_LIH    = 4'b0101;
  localparam logic [5:0]       OPC_CAL    = 6'b001010;
  localparam logic [3:0]       OPC_LM     = 4'b1011;
  localparam logic [3:0]       OPC_SM     = 4'b1001;
  localparam logic [4:0]       OPC_JP_IMM = 5'b00011;
  localparam logic [4:0]       OPC_JP_REL = 5'b00100;
  localparam logic [2:0]       OPC_JP_REG = 3'b111;
  localparam logic [INS_W-1:0] OPC_HALT   = 16'h0001;
  localparam logic [INS_W-1:0] OPC_NOP    = 16'h0000;

  // Low two bits of the cond field; bit 2 is the polarity flag.
  localparam logic [1:0] CC_UC = 2'b00;
  localparam logic [1:0] CC_ZE = 2'b01;
  localparam logic [1:0] CC_CA = 2'b10;
  localparam logic [1:0] CC_SG = 2'b11;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_THB = 4'b1111;

  typedef struct packed {
    req_kind_e          kind;
    logic [REG_W-1:0]   rw;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [OP_W-1:0]    op;
    logic [COND_W-1:0]  cond;
    logic [IMM_W-1:0]   imm;
  } req_fields_t;

  function automatic logic s8(input logic [IMM_W-1:0] x);
    return (x[15:7] == '0) || (x[15:7] == '1);
  endfunction

endpackage

// File: rtl/inst_enc_if.sv
// Request and instruction-word handshakes of the instruction encoder.
// master = program generator / consumer side, slave = encoder.
interface inst_enc_if;
  import pu_isa_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [KIND_W-1:0]  req_kind;
  logic [REG_W-1:0]   req_rw;
  logic [REG_W-1:0]   req_ra;
  logic [REG_W-1:0]   req_rb;
  logic [OP_W-1:0]    req_op;
  logic [COND_W-1:0]  req_cond;
  logic [IMM_W-1:0]   req_imm;

  logic               ins_valid;
  logic               ins_ready;
  logic [INS_W-1:0]   ins;
  logic               ins_last;
  logic               err;

  modport master (
    output req_valid, req_kind, req_rw, req_ra, req_rb, req_op, req_cond,
           req_imm, ins_ready,
    input  req_ready, ins_valid, ins, ins_last, err
  );

  modport slave (
    input  req_valid, req_kind, req_rw, req_ra, req_rb, req_op, req_cond,
           req_imm, ins_ready,
    output req_ready, ins_valid, ins, ins_last, err
  );

endinterface

// File: rtl/inst_fmt.sv
// Combinational formatter: (request fields, step) -> {word, last, range_err}.
// Macro INST_ENC_SHORT_EN enables the single-word LI / JP-imm short forms.
module inst_fmt
  import pu_isa_pkg::*;
(
  input  req_fields_t       fields_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [INS_W-1:0]  word_o,
  output logic              last_o,
  output logic              range_err_o
);

`ifdef INST_ENC_SHORT_EN
  localparam bit SHORT_EN = 1'b1;
`else
  localparam bit SHORT_EN = 1'b0;
`endif

  logic       fits_s8;
  logic       short_ok;
  logic [7:0] lo;
  logic [7:0] hi;

  assign fits_s8  = s8(fields_i.imm);
  assign short_ok = SHORT_EN && fits_s8;
  assign lo       = fields_i.imm[7:0];
  assign hi       = fields_i.imm[15:8];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    word_o      = OPC_NOP;
    last_o      = 1'b1;
    range_err_o = 1'b0;
    case (fields_i.kind)
      K_LDC: begin
        if (short_ok) begin
          word_o = {OPC_LI, fields_i.rw, lo};
        end else if (step_i == 2'd0) begin
          word_o = {OPC_LIL, fields_i.rw, fields_i.rw, lo};
          last_o = 1'b0;
        end else begin
          word_o = {OPC_LIH, fields_i.rw, fields_i.rw, hi};
        end
      end
      K_CAL:  word_o = {OPC_CAL, fields_i.rw, fields_i.op, fields_i.ra, fields_i.rb};
      K_LDM: begin
        word_o      = {OPC_LM, fields_i.rw, fields_i.ra, lo};
        range_err_o = !fits_s8;
      end
      K_STM: begin
        word_o      = {OPC_SM, fields_i.ra, fields_i.rb, lo};
        range_err_o = !fits_s8;
      end
      K_FARJ: begin
        // Long form loads the target into ra (scratch) then jumps through it.
        if (short_ok) begin
          word_o = {OPC_JP_IMM, fields_i.cond, lo};
        end else begin
          case (step_i)
            2'd0: begin
              word_o = {OPC_LIL, fields_i.ra, fields_i.ra, lo};
              last_o = 1'b0;
            end
            2'd1: begin
              word_o = {OPC_LIH, fields_i.ra, fields_i.ra, hi};
              last_o = 1'b0;
            end
            default: word_o = {OPC_JP_REG, fields_i.ra, fields_i.cond, 8'h00};
          endcase
        end
      end
      K_BRR: begin
        word_o      = {OPC_JP_REL, fields_i.cond, lo};
        range_err_o = !fits_s8;
      end
      K_HALT: word_o = OPC_HALT;
      K_NOP:  word_o = OPC_NOP;
    endcase
  end

endmodule

// File: rtl/inst_enc.sv
// Instruction encoder/expander: one request in, one to three PU words out.
// Short-form selection is set by INST_ENC_SHORT_EN inside inst_fmt.
module inst_enc
  import pu_isa_pkg::*;
#(
  parameter int unsigned PU_NUM = 0
) (
  input logic       clk,
  input logic       rst_n,
  inst_enc_if.slave bus
);

  if (PU_NUM > 32'd65535) begin : g_pu_num_range
    $error("inst_enc: PU_NUM out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_W0, ST_W1, ST_W2} state_e;

  state_e            state_q, state_d;
  req_fields_t       fields_q, fields_d;
  logic              err_q, err_d;

  req_fields_t       req_now;
  req_fields_t       fmt_fields;
  logic [STEP_W-1:0] fmt_step;
  logic [INS_W-1:0]  fmt_word;
  logic              fmt_last;
  logic              fmt_range_err;
  logic              busy;

  assign req_now = '{kind: req_kind_e'(bus.req_kind), rw: bus.req_rw,
                     ra: bus.req_ra, rb: bus.req_rb, op: bus.req_op,
                     cond: bus.req_cond, imm: bus.req_imm};

  // In IDLE the formatter inspects the incoming request so a range error is
  // known at accept time; otherwise it formats the latched request.
  always_comb begin
    fmt_fields = fields_q;
    fmt_step   = 2'd0;
    case (state_q)
      ST_IDLE: fmt_fields = req_now;
      ST_W0:   fmt_step   = 2'd0;
      ST_W1:   fmt_step   = 2'd1;
      ST_W2:   fmt_step   = 2'd2;
    endcase
  end

  inst_fmt u_fmt (
    .fields_i    (fmt_fields),
    .step_i      (fmt_step),
    .word_o      (fmt_word),
    .last_o      (fmt_last),
    .range_err_o (fmt_range_err)
  );

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          fields_d = req_now;
          err_d    = fmt_range_err;
          state_d  = fmt_range_err ? ST_IDLE : ST_W0;
        end
      end
      default: begin
        if (bus.ins_ready) begin
          if (fmt_last) begin
            state_d = ST_IDLE;
          end else begin
            case (state_q)
              ST_W0:   state_d = ST_W1;
              ST_W1:   state_d = ST_W2;
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      // NOTE: the holding register is cleared too, so no stale request
      // survives a reset even though outputs are gated by state.
      fields_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make all flops sample pre-edge values.
      state_q  <= state_d;
      fields_q <= fields_d;
      err_q    <= err_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign bus.req_ready = !busy;
  assign bus.ins_valid = busy;
  assign bus.ins       = busy ? fmt_word : '0;
  assign bus.ins_last  = busy & fmt_last;
  assign bus.err       = err_q;

endmodule

// File: doc/inst_enc.md
# inst_enc

Instruction encoder/expander for the 16-bit PU. Accepts one symbolic request (kind plus register, condition and immediate fields) over a valid/ready handshake and emits one to three encoded 16-bit instruction words over a second valid/ready handshake, in the exact formats the PU decoder consumes. It sits between a program generator or loader and instruction memory, and expands pseudo-ops (16-bit constant load, far jump) into LIL/LIH/JP sequences.

## Interface
Parameters:
- PU_NUM, 0, PU index (debug tagging only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_kind  in  3  0 LDC, 1 CAL, 2 LDM, 3 STM, 4 FARJ, 5 BRR, 6 HALT, 7 NOP
- req_rw / req_ra / req_rb  in  2 each  register fields
- req_op  in  4  ALU op (ADD=0000 … THB=1111)
- req_cond  in  3  {p,ff}; ff: 00 UC, 01 ZE, 10 CA, 11 SG
- req_imm  in  16  immediate / target / offset
- ins_valid  out  1  word valid
- ins_ready  in  1  consumer accepts word
- ins  out  16  encoded instruction
- ins_last  out  1  final word of current request
- err  out  1  one-cycle pulse: request rejected (immediate out of range)

## Operation
- s8(x): true when x[15:7] are all 0 or all 1.
- LDC rw,imm: short form when s8(imm) is true: LI 0000_01 rw imm[7:0]. Otherwise two words: LIL 0100 rw rw imm[7:0], then LIH 0101 rw rw imm[15:8].
- CAL: one word, 00101 0 rw op ra rb.
- LDM rw=[ra+s8]: one word, 1011 rw ra imm[7:0]. Requires s8(imm).
- STM [ra+s8]=rb: one word, 1001 ra rb imm[7:0]. Requires s8(imm).
- FARJ cond, imm, with req_ra as scratch:
  - Short form when s8(imm) is true: 00011 cond imm[7:0].
  - Otherwise three words: LIL ra,ra,lo; LIH ra,ra,hi; 111 ra cond 0x00.
- BRR cond, PC+s8: one word, 00100 cond imm[7:0]. Requires s8(imm).
- HALT emits 0x0001. NOP emits 0x0000.
- Range violation: the request is still accepted, err pulses in the following cycle, and no word is emitted.
- FSM states: IDLE, W0, W1, W2.
  - IDLE: req_ready=1. On accept, latch all fields and go to W0, or return to IDLE with err=1 on a range violation.
  - Wn: ins_valid=1 and ins holds the word for that step.
  - On ins_valid&ins_ready: go to the next Wn, or to IDLE if ins_last.
- Unused register/op fields of a kind are ignored.

## Timing
- Reset values: state IDLE, req_ready=1, ins_valid=0, ins=0x0000, ins_last=0, err=0. All holding registers are cleared.
- Request accepted in cycle N → first word valid in cycle N+1 (registered output).
- Each further word is valid one cycle after the previous word is accepted.
- req_ready=0 whenever state≠IDLE, so there is no overlap between requests.
- Worst-case throughput is one request per words+1 cycles.
- While ins_valid=1 and ins_ready=0, ins and ins_last are held stable.
- ins_valid never drops without a handshake.
- rst_n asserted mid-sequence: outputs return to their reset values immediately. The partial sequence is abandoned and its remaining words are never emitted.
- err is high for exactly the one cycle after the rejecting accept.

## Configuration
- INST_ENC_SHORT_EN
  - Defined: LDC and FARJ use the single-word short forms when s8(imm) is true.
  - Undefined: LDC always emits LIL+LIH, and FARJ always emits LIL+LIH+JP, regardless of imm.
  - CAL, LDM, STM, BRR, HALT and NOP are unaffected by the macro.

## Structure
- Shared package pu_isa_pkg holds:
  - the req_kind enum;
  - opcode prefix constants (LI, LIL, LIH, CAL, LM, SM, JP-imm, JP-rel, JP-reg, HALT);
  - the cond field values UC/ZE/CA/SG;
  - the ALU op constants;
  - width constants shared with pu.vh.
- Sub-module inst_fmt: a combinational formatter mapping (latched fields, step index) → {word, last, range_err}. The FSM and handshakes stay in inst_enc.

## Test plan
- LDC rw=2, imm=0x1234, macro on → 0x4A34 then 0x5A12. ins_last is set on the second word only.
- LDC rw=1, imm=0xFFF0 → with macro: 0x05F0 (last). Without macro: 0x45F0 then 0x55FF.
- CAL rw=3, op=ADD, ra=1, rb=2 → 0x2B06 (last). HALT → 0x0001.
- FARJ ra=3, cond=101, imm=0x0200 → 0x4F00, 0x5F02, 0xFD00. Hold ins_ready=0 for 3 cycles on the second word → word stays 0x5F02 and valid.
- LDM rw=0, ra=2, imm=0x0005 → 0xB205. With imm=0x0100 → err pulses for 1 cycle, no ins_valid, req_ready=1 in the next cycle.
- Assert rst_n low during the second FARJ word → ins_valid=0 and req_ready=1 immediately. After release, a NOP request emits 0x0000 only.
